// File: rtl/pll_lock_reset_seq.sv
// Turns an asynchronous PLL LOCK into a clean system reset, pulsing the PLL reset on lock timeout.
// Optional lock-loss event counter enabled by defining LOCK_LOSS_COUNT_EN.
module pll_lock_reset_seq #(
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048575,
  parameter int unsigned PLLRST_CYCLES  = 8,
  parameter int unsigned CNT_W          = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lost_count
);

  typedef enum logic [2:0] {StWaitLock, StPllRst, StStable, StHold, StRun} state_e;

  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLLRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;

  always_comb begin
    lock_meta_d = locked;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StWaitLock: begin
        if (lock_s_q) begin
          // The cycle that first sees lock counts as stable cycle one.
          if (STABLE_CYCLES == 1) begin
            state_d = StHold;
            cnt_d   = '0;
          end else begin
            state_d = StStable;
            cnt_d   = CntOne;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StPllRst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStable: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHold: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they change on the transition edge.
    pll_rst_d   = (state_d == StPllRst);
    sys_rst_n_d = (state_d == StRun);
    ready_d     = (state_d == StRun);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic       lock_lost;
  logic [7:0] lost_count_q, lost_count_d;

  assign lock_lost = (state_q == StRun) && (state_d == StWaitLock);

  always_comb begin
    lost_count_d = lost_count_q;
    if (lock_lost && (lost_count_q != 8'hff)) begin
      lost_count_d = lost_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lost_count_q <= 8'd0;
    end else begin
      lost_count_q <= lost_count_d;
    end
  end

  assign lost_count = lost_count_q;
`else
  assign lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Randomised bench for pll_lock_reset_seq against a streak/timeout model of the lock sequencer.
module tb_pll_lock_reset_seq;

  localparam int S = 8;
  localparam int H = 4;
  localparam int T = 32;
  localparam int P = 3;

  logic       clock;
  logic       reset_n;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lost_count;

  int tests;
  int fails;
  int cycle;

  // Model: lock synchroniser as a 2-deep shift, then run-length counting of synced lock.
  int m_sync0, m_sync1;
  int m_streak;
  int m_wait;
  int m_pulse;
  int m_loss;

  pll_lock_reset_seq #(
    .STABLE_CYCLES (S),
    .HOLD_CYCLES   (H),
    .TIMEOUT_CYCLES(T),
    .PLLRST_CYCLES (P),
    .CNT_W         (21)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .lost_count(lost_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model_step();
    int ls;
    if (!reset_n) begin
      m_sync0 = 0; m_sync1 = 0; m_streak = 0; m_wait = 0; m_pulse = 0; m_loss = 0;
    end else begin
      ls = m_sync1;
      if (m_pulse > 0) begin
        m_pulse--;
        m_streak = 0;
        m_wait   = 0;
      end else if (ls != 0) begin
        if (m_streak < 10000) m_streak++;
        m_wait = 0;
      end else if (m_streak > 0) begin
        if (m_streak >= S + H && m_loss < 255) m_loss++;
        m_streak = 0;
        m_wait   = 0;
      end else if (m_wait == T - 1) begin
        m_pulse = P;
        m_wait  = 0;
      end else begin
        m_wait++;
      end
      m_sync1 = m_sync0;
      m_sync0 = int'(locked);
    end
  endtask

  function automatic int exp_lost();
`ifdef LOCK_LOSS_COUNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
    model_step();
    chk("sys_rst_n", int'(sys_rst_n), (m_streak >= S + H) ? 1 : 0);
    chk("ready", int'(ready), (m_streak >= S + H) ? 1 : 0);
    chk("pll_rst", int'(pll_rst), (m_pulse > 0) ? 1 : 0);
    chk("lost_count", int'(lost_count), exp_lost());
  endtask

  task automatic do_reset(input int lock_val);
    reset_n = 1'b0;
    locked  = lock_val[0];
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic edges_until_rst(input int want, output int n);
    n = 0;
    while (int'(sys_rst_n) != want && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int rise1, rise2, width, prev, seen_run;
    tests = 0; fails = 0; cycle = 0;
    reset_n = 1'b0;
    locked  = 1'b0;
    m_sync0 = 0; m_sync1 = 0; m_streak = 0; m_wait = 0; m_pulse = 0; m_loss = 0;

    // 1: lock present from release, expect release after 2 + 8 + 4 edges.
    do_reset(1);
    edges_until_rst(1, n);
    chk("t1_release_latency", n, 2 + S + H);
    chk("t1_ready", int'(ready), 1);

    // 2: single-cycle drop while STABLE count is 5 restarts the count.
    do_reset(1);
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    edges_until_rst(1, n);
    chk("t2_glitch_restart", n, 2 + S + H);

    // 3: lock never arrives, PLL reset pulses of width 3 every 35 cycles.
    do_reset(0);
    rise1 = -1; rise2 = -1; width = 0; prev = 0; seen_run = 0;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (sys_rst_n) seen_run = 1;
      if (pll_rst && prev == 0) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      if (pll_rst && rise2 < 0) width++;
      prev = int'(pll_rst);
    end
    chk("t3_first_pulse", rise1, T);
    chk("t3_period", rise2 - rise1, T + P);
    chk("t3_width", width, P);
    chk("t3_never_released", seen_run, 0);

    // 4: loss in RUN drops sys_rst_n within 3 edges, relock releases after 14.
    do_reset(1);
    edges_until_rst(1, n);
    locked = 1'b0;
    edges_until_rst(0, n);
    chk("t4_loss_latency", n, 3);
    locked = 1'b1;
    edges_until_rst(1, n);
    chk("t4_relock_latency", n, 2 + S + H);

    // 5: 300 loss events saturate the counter; reset clears it.
    do_reset(1);
    for (int k = 0; k < 300; k++) begin
      locked = 1'b1;
      repeat (16) tick();
      locked = 1'b0;
      repeat (4) tick();
    end
`ifdef LOCK_LOSS_COUNT_EN
    chk("t5_lost_saturated", int'(lost_count), 255);
`else
    chk("t5_lost_tied_zero", int'(lost_count), 0);
`endif
    reset_n = 1'b0;
    tick();
    chk("t5_lost_cleared", int'(lost_count), 0);

    // 6: reset during HOLD returns all outputs to reset values, then restarts.
    do_reset(1);
    repeat (11) tick();
    reset_n = 1'b0;
    tick();
    chk("t6_sys_rst_n", int'(sys_rst_n), 0);
    chk("t6_ready", int'(ready), 0);
    chk("t6_pll_rst", int'(pll_rst), 0);
    reset_n = 1'b1;
    edges_until_rst(1, n);
    chk("t6_restart_latency", n, 2 + S + H);

    // Random segments: long locks, glitches, long losses into timeout, occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      int mode;
      int len;
      mode = int'($urandom_range(0, 9));
      if (mode < 4) begin
        locked = 1'b1;
        len = int'($urandom_range(5, 40));
      end else if (mode < 7) begin
        locked = 1'b0;
        len = int'($urandom_range(1, 3));
      end else if (mode < 9) begin
        locked = 1'b0;
        len = int'($urandom_range(10, 80));
      end else begin
        reset_n = 1'b0;
        locked  = $urandom_range(0, 1) != 0;
        len = int'($urandom_range(1, 3));
      end
      repeat (len) tick();
      reset_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
